// File: rtl/mem_access_stage.sv
// MEM stage and MEM/WB register: data-memory req/ack access,
// upstream stall, timeout abort and misalignment error flag.
module mem_access_stage #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic        MemReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] MemData_i,
  input  logic [4:0]  rd_addr_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        RegWrite_o,
  output logic        MemReg_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] ALUResult_o,
  output logic [4:0]  rd_addr_o,
  output logic        err_o
);

  typedef enum logic {IDLE, ACCESS} state_e;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              lat_rw_q, lat_rw_d;
  logic              lat_mr_q, lat_mr_d;
  logic [4:0]        lat_rd_q, lat_rd_d;
  logic              wb_rw_q, wb_rw_d;
  logic              wb_mr_q, wb_mr_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [31:0]       wb_alu_q, wb_alu_d;
  logic [31:0]       wb_rdata_q, wb_rdata_d;
  logic              err_q, err_d;
  logic              stall;
  logic              mem_op;
  logic              aligned;

  assign mem_op  = MemRead_i | MemWrite_i;
  assign aligned = (ALUResult_i[1:0] == 2'b00);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lat_rw_d   = lat_rw_q;
    lat_mr_d   = lat_mr_q;
    lat_rd_d   = lat_rd_q;
    wb_rw_d    = 1'b0;
    wb_mr_d    = 1'b0;
    wb_rd_d    = 5'd0;
    wb_alu_d   = wb_alu_q;
    wb_rdata_d = wb_rdata_q;
    err_d      = err_q;
    stall      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!mem_op) begin
          wb_rw_d    = RegWrite_i;
          wb_mr_d    = MemReg_i;
          wb_rd_d    = rd_addr_i;
          wb_alu_d   = ALUResult_i;
          wb_rdata_d = 32'd0;
        end else if (aligned) begin
          stall    = 1'b1;
          req_d    = 1'b1;
          we_d     = MemWrite_i;
          addr_d   = ALUResult_i;
          wdata_d  = MemData_i;
          lat_rw_d = RegWrite_i;
          lat_mr_d = MemReg_i;
          lat_rd_d = rd_addr_i;
          cnt_d    = '0;
          state_d  = ACCESS;
        end else begin
          err_d = 1'b1;
        end
      end
      ACCESS: begin
        if (mem_ack_i) begin
          wb_rw_d    = lat_rw_q;
          wb_mr_d    = lat_mr_q;
          wb_rd_d    = lat_rd_q;
          wb_alu_d   = addr_q;
          wb_rdata_d = we_q ? 32'd0 : mem_rdata_i;
          req_d      = 1'b0;
          state_d    = IDLE;
        end else if (cnt_q == LAST) begin
          // abort releases the pipeline this cycle
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      lat_rw_q   <= 1'b0;
      lat_mr_q   <= 1'b0;
      lat_rd_q   <= 5'd0;
      wb_rw_q    <= 1'b0;
      wb_mr_q    <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_alu_q   <= 32'd0;
      wb_rdata_q <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lat_rw_q   <= lat_rw_d;
      lat_mr_q   <= lat_mr_d;
      lat_rd_q   <= lat_rd_d;
      wb_rw_q    <= wb_rw_d;
      wb_mr_q    <= wb_mr_d;
      wb_rd_q    <= wb_rd_d;
      wb_alu_q   <= wb_alu_d;
      wb_rdata_q <= wb_rdata_d;
      err_q      <= err_d;
    end
  end

  // reset forces the stall low even with a memory op on the inputs
  assign stall_o     = stall & rst_i;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign RegWrite_o  = wb_rw_q;
  assign MemReg_o    = wb_mr_q;
  assign rd_addr_o   = wb_rd_q;
  assign ALUResult_o = wb_alu_q;
  assign ReadData_o  = wb_rdata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: vector table for
// pass-through ops, hand sequences for multi-cycle accesses.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rw_i, mr_i, rdn_i, wrn_i;
  logic [31:0] alu_i, wd_i;
  logic [4:0]  rd_i;
  logic        stall, req, we;
  logic [31:0] addr, wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        rw_o, mr_o;
  logic [31:0] rdat_o, alu_o;
  logic [4:0]  rd_o;
  logic        err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .RegWrite_i(rw_i), .MemReg_i(mr_i),
    .MemRead_i(rdn_i), .MemWrite_i(wrn_i),
    .ALUResult_i(alu_i), .MemData_i(wd_i),
    .rd_addr_i(rd_i), .stall_o(stall),
    .mem_req_o(req), .mem_we_o(we),
    .mem_addr_o(addr), .mem_wdata_o(wdata),
    .mem_ack_i(ack), .mem_rdata_i(rdata),
    .RegWrite_o(rw_o), .MemReg_o(mr_o),
    .ReadData_o(rdat_o), .ALUResult_o(alu_o),
    .rd_addr_o(rd_o), .err_o(err)
  );

  typedef struct {
    logic        rw, mr;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        e_rw, e_mr;
    logic [31:0] e_alu;
    logic [4:0]  e_rd;
  } vec_t;

  vec_t vt[4];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  task automatic set_in(input logic rw, input logic mr,
                        input logic rn, input logic wn,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [4:0] r);
    rw_i = rw; mr_i = mr; rdn_i = rn; wrn_i = wn;
    alu_i = a; wd_i = d; rd_i = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int n;

  initial begin
    vt[0] = '{1'b1, 1'b0, 32'h0000_0005, 5'd3,
              1'b1, 1'b0, 32'h0000_0005, 5'd3};
    vt[1] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 5'd31,
              1'b1, 1'b1, 32'hFFFF_FFFF, 5'd31};
    vt[2] = '{1'b0, 1'b0, 32'h0000_0102, 5'd7,
              1'b0, 1'b0, 32'h0000_0102, 5'd7};
    vt[3] = '{1'b1, 1'b0, 32'h8000_0003, 5'd1,
              1'b1, 1'b0, 32'h8000_0003, 5'd1};

    rst_n = 1'b0; ack = 1'b0; rdata = 32'd0;
    set_in(0, 0, 0, 0, 32'd0, 32'd0, 5'd0);
    #1;
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rw", {31'd0, rw_o}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_alu", alu_o, 32'd0);
    step();
    #3 rst_n = 1'b1;
    step();

    // pass-through table
    for (int i = 0; i < 4; i++) begin
      set_in(vt[i].rw, vt[i].mr, 0, 0,
             vt[i].alu, 32'hA5A5_A5A5, vt[i].rd);
      #1;
      chk("pt_stall", {31'd0, stall}, 32'd0);
      step();
      chk("pt_rw", {31'd0, rw_o}, {31'd0, vt[i].e_rw});
      chk("pt_mr", {31'd0, mr_o}, {31'd0, vt[i].e_mr});
      chk("pt_alu", alu_o, vt[i].e_alu);
      chk("pt_rd", {27'd0, rd_o}, {27'd0, vt[i].e_rd});
      chk("pt_rdata", rdat_o, 32'd0);
      chk("pt_req", {31'd0, req}, 32'd0);
      chk("pt_err", {31'd0, err}, 32'd0);
    end

    // load 0x100, two wait cycles
    set_in(1, 1, 1, 0, 32'h100, 32'd0, 5'd5);
    #1;
    chk("ld_stall0", {31'd0, stall}, 32'd1);
    chk("ld_req0", {31'd0, req}, 32'd0);
    step();
    chk("ld_req1", {31'd0, req}, 32'd1);
    chk("ld_we", {31'd0, we}, 32'd0);
    chk("ld_addr", addr, 32'h100);
    chk("ld_bub_rw1", {31'd0, rw_o}, 32'd0);
    chk("ld_bub_rd1", {27'd0, rd_o}, 32'd0);
    chk("ld_alu_hold", alu_o, 32'h8000_0003);
    chk("ld_stall1", {31'd0, stall}, 32'd1);
    step();
    chk("ld_req2", {31'd0, req}, 32'd1);
    chk("ld_bub_rw2", {31'd0, rw_o}, 32'd0);
    chk("ld_stall2", {31'd0, stall}, 32'd1);
    step();
    chk("ld_req3", {31'd0, req}, 32'd1);
    chk("ld_addr3", addr, 32'h100);
    ack = 1'b1; rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_stall_ack", {31'd0, stall}, 32'd0);
    step();
    ack = 1'b0; rdata = 32'd0;
    set_in(0, 0, 0, 0, 32'd0, 32'd0, 5'd0);
    chk("ld_rdata", rdat_o, 32'hDEAD_BEEF);
    chk("ld_mr", {31'd0, mr_o}, 32'd1);
    chk("ld_rw", {31'd0, rw_o}, 32'd1);
    chk("ld_rd", {27'd0, rd_o}, 32'd5);
    chk("ld_alu", alu_o, 32'h100);
    chk("ld_req_end", {31'd0, req}, 32'd0);

    // store 0x204, read+write both set, ack first cycle
    set_in(0, 0, 1, 1, 32'h204, 32'h1234_5678, 5'd0);
    #1;
    chk("st_stall0", {31'd0, stall}, 32'd1);
    step();
    chk("st_req", {31'd0, req}, 32'd1);
    chk("st_we", {31'd0, we}, 32'd1);
    chk("st_wdata", wdata, 32'h1234_5678);
    chk("st_addr", addr, 32'h204);
    ack = 1'b1; rdata = 32'hAAAA_5555;
    #1;
    chk("st_stall1", {31'd0, stall}, 32'd0);
    step();
    ack = 1'b0;
    set_in(0, 0, 0, 0, 32'd0, 32'd0, 5'd0);
    chk("st_rw", {31'd0, rw_o}, 32'd0);
    chk("st_rdata", rdat_o, 32'd0);
    chk("st_req_end", {31'd0, req}, 32'd0);
    chk("st_err", {31'd0, err}, 32'd0);

    // misaligned load
    set_in(1, 1, 1, 0, 32'h102, 32'd0, 5'd4);
    #1;
    chk("mis_stall", {31'd0, stall}, 32'd0);
    step();
    set_in(0, 0, 0, 0, 32'd0, 32'd0, 5'd0);
    chk("mis_req", {31'd0, req}, 32'd0);
    chk("mis_err", {31'd0, err}, 32'd1);
    chk("mis_rw", {31'd0, rw_o}, 32'd0);
    step();
    chk("mis_err_sticky", {31'd0, err}, 32'd1);

    // timeout with TIMEOUT_CYC=4
    set_in(1, 1, 1, 0, 32'h300, 32'd0, 5'd6);
    #1;
    n = 0;
    while (stall && n < 10) begin
      n++;
      step();
    end
    chk("to_stall_cycles", n, 32'd4);
    chk("to_req_last", {31'd0, req}, 32'd1);
    step();
    chk("to_req", {31'd0, req}, 32'd0);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_rw", {31'd0, rw_o}, 32'd0);
    set_in(1, 0, 0, 0, 32'h55, 32'd0, 5'd9);
    ack = 1'b1; rdata = 32'h1111_2222;
    #1;
    chk("late_ack_stall", {31'd0, stall}, 32'd0);
    step();
    ack = 1'b0;
    chk("late_ack_rw", {31'd0, rw_o}, 32'd1);
    chk("late_ack_alu", alu_o, 32'h55);
    chk("late_ack_rdata", rdat_o, 32'd0);
    chk("late_ack_req", {31'd0, req}, 32'd0);

    // reset mid-access
    set_in(1, 1, 1, 0, 32'h400, 32'd0, 5'd8);
    step();
    step();
    chk("ra_req_pre", {31'd0, req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ra_req", {31'd0, req}, 32'd0);
    chk("ra_stall", {31'd0, stall}, 32'd0);
    chk("ra_addr", addr, 32'd0);
    chk("ra_alu", alu_o, 32'd0);
    chk("ra_err", {31'd0, err}, 32'd0);
    step();
    set_in(1, 0, 0, 0, 32'h7, 32'd0, 5'd2);
    ack = 1'b1;
    #2 rst_n = 1'b1;
    step();
    ack = 1'b0;
    chk("ra_pt_rw", {31'd0, rw_o}, 32'd1);
    chk("ra_pt_alu", alu_o, 32'h7);
    chk("ra_pt_rd", {27'd0, rd_o}, 32'd2);
    chk("ra_pt_rdata", rdat_o, 32'd0);
    chk("ra_pt_req", {31'd0, req}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
